qsys_nios2_qsys_jtag_scan_master: RTL and testbench

On-chip scan initiator that drives the Nios II JTAG debug module's virtual-JTAG-side port (tck, tdi, ir_in, vs_uir/cdr/sdr/udr, jtag_state_rti) from the system clock, in place of the sld_virtual_jtag_basic hub. A host-side agent (test sequencer or soft debug bridge) issues one command at a time: a 2-bit IR value and a 38-bit DR value. The block generates a divided TCK, runs the full UIR→CDR→SDR→UDR→RTI sequence, and returns the 38-bit word shifted out of tdo together with the captured ir_out. It lets simulation and self-test drive the debug module without a physical JTAG cable.

---
 rtl/qsys_nios2_qsys_jtag_scan_master.sv | 120 ++++++++++++
 tb/tb_qsys_nios2_qsys_jtag_scan_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_nios2_qsys_jtag_scan_master.sv
// qsys_nios2_qsys_jtag_scan_master: drives the Nios II debug module's virtual-JTAG port from clk,
// running one UIR/CDR/SDR/UDR/RTI scan per command and returning the captured DR and IR.
module qsys_nios2_qsys_jtag_scan_master #(
    parameter int TCK_DIV    = 2,
    parameter int DR_WIDTH   = 38,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [1:0]          rsp_ir,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [1:0]          ir_in,
    input  logic [1:0]          ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);
    localparam int DW = $clog2(2 * TCK_DIV) + 1;
    localparam int CW = $clog2(DR_WIDTH + RTI_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, DONE} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d, rsp_dr_d;
    logic [1:0]          ir_in_d, rsp_ir_d;
    logic                rise, fall, last, active_d, tck_d, tdi_d;

    // div_q walks one TCK period: low half, then high half; rise/fall mark the edges that flip tck
    assign rise = div_q == DW'(TCK_DIV - 1);
    assign fall = div_q == DW'(2 * TCK_DIV - 1);
    assign last = cnt_q == (state_q == SDR ? CW'(DR_WIDTH - 1) :
                            state_q == RTI ? CW'(RTI_CYCLES - 1) : CW'(0));

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        ir_in_d  = ir_in;
        rsp_dr_d = rsp_dr;
        rsp_ir_d = rsp_ir;
        if (state_q == IDLE) begin
            if (cmd_valid) begin
                state_d = UIR;
                ir_in_d = cmd_ir;
                sr_d    = cmd_dr;
            end
        end else if (state_q == DONE) begin
            if (rsp_ready) state_d = IDLE;
        end else begin
            div_d = fall ? '0 : div_q + 1'b1;
            // one register both shifts tdi out of bit 0 and collects tdo into the top bit
            if (rise && state_q == SDR) sr_d = {tdo, sr_q[DR_WIDTH-1:1]};
            if (rise && state_q == CDR) rsp_ir_d = ir_out;
            if (fall) begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last)
                    state_d = state_q == UIR ? CDR :
                              state_q == CDR ? SDR :
                              state_q == SDR ? UDR :
                              state_q == UDR ? RTI : DONE;
            end
        end
        if (state_q == RTI && state_d == DONE) rsp_dr_d = sr_q;
        active_d = !(state_d inside {IDLE, DONE});
        tck_d    = active_d && (div_d >= DW'(TCK_DIV));
        tdi_d    = (state_d == SDR) && (fall ? sr_q[0] : tdi);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            div_q          <= '0;
            cnt_q          <= '0;
            sr_q           <= '0;
            ir_in          <= '0;
            rsp_dr         <= '0;
            rsp_ir         <= '0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            cnt_q          <= cnt_d;
            sr_q           <= sr_d;
            ir_in          <= ir_in_d;
            rsp_dr         <= rsp_dr_d;
            rsp_ir         <= rsp_ir_d;
            cmd_ready      <= state_d == IDLE;
            rsp_valid      <= state_d == DONE;
            tck            <= tck_d;
            tdi            <= tdi_d;
            vs_uir         <= state_d == UIR;
            vs_cdr         <= state_d == CDR;
            vs_sdr         <= state_d == SDR;
            vs_udr         <= state_d == UDR;
            jtag_state_rti <= state_d inside {IDLE, RTI, DONE};
        end
    end
endmodule

// File: tb/tb_qsys_nios2_qsys_jtag_scan_master.sv
// tb_qsys_nios2_qsys_jtag_scan_master: scoreboard bench for the scan master with default parameters
// (172-clk latency, 4 clk per TCK period).
module tb_qsys_nios2_qsys_jtag_scan_master;
    logic        clk = 0, reset_n, cmd_valid, rsp_ready;
    logic [1:0]  cmd_ir, ir_out, rsp_ir, ir_in;
    logic [37:0] cmd_dr, rsp_dr, model;
    logic        cmd_ready, rsp_valid, tck, tdi, tdo, loop;
    logic        vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

    typedef struct { logic [1:0] cir; logic [1:0] ir; logic [37:0] dr; } exp_t;
    exp_t q[$];

    int checks = 0, failures = 0, cyc = 0, cyc_acc = 0, sdr_base = 0;
    int r_uir = 0, r_cdr = 0, r_sdr = 0, r_udr = 0, r_rti = 0, sdr_hi = 0, multi_err = 0, tdi_err = 0;
    logic p_tck = 0, p_tdi = 0, p_rst = 0;

    qsys_nios2_qsys_jtag_scan_master dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dr(rsp_dr), .rsp_ir(rsp_ir), .tck(tck), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
        .vs_udr(vs_udr), .jtag_state_rti(jtag_state_rti)
    );

    always #5 clk = ~clk;

    // the model's bit i is presented during SDR period i of the current scan
    assign tdo = loop ? tdi : ((r_sdr - sdr_base) < 38 ? model[6'(r_sdr - sdr_base)] : 1'b0);

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tck && !p_tck) begin
            if (vs_uir) r_uir++;
            if (vs_cdr) r_cdr++;
            if (vs_sdr) r_sdr++;
            if (vs_udr) r_udr++;
            if (jtag_state_rti) r_rti++;
        end
        if (vs_sdr) sdr_hi++;
        if ($countones({vs_uir, vs_cdr, vs_sdr, vs_udr}) > 1) multi_err++;
        if (reset_n && p_rst && tdi !== p_tdi && !(p_tck && !tck)) tdi_err++;
        p_tck = tck;
        p_tdi = tdi;
        p_rst = reset_n;
    end

    task automatic send(input logic [1:0] ir, input logic [37:0] dr, input logic [37:0] exp_dr);
        int n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL send_ready got=%b want=1", cmd_ready); end
        sdr_base = r_sdr;
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1;
        q.push_back('{cir: ir, ir: ir_out, dr: exp_dr});
        @(negedge clk);
        cmd_valid = 0;
        cyc_acc = cyc;
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL accept cmd_ready got=%b want=0", cmd_ready); end
    endtask

    task automatic collect();
        int n = 0, ir_bad = 0;
        exp_t e;
        if (q.size() == 0) begin
            checks++; failures++; $display("FAIL scoreboard_empty got=0 want>0");
            return;
        end
        e = q.pop_front();
        while (!rsp_valid && n < 1000) begin
            if (ir_in !== e.cir) ir_bad++;
            @(negedge clk); n++;
        end
        checks++;
        if (cyc - cyc_acc !== 172) begin failures++; $display("FAIL latency got=%0d want=172", cyc - cyc_acc); end
        checks++;
        if (rsp_dr !== e.dr) begin failures++; $display("FAIL rsp_dr got=%h want=%h", rsp_dr, e.dr); end
        checks++;
        if (rsp_ir !== e.ir) begin failures++; $display("FAIL rsp_ir got=%b want=%b", rsp_ir, e.ir); end
        checks++;
        if (ir_bad != 0 || ir_in !== e.cir) begin failures++; $display("FAIL ir_in_hold got=%b bad=%0d want=%b", ir_in, ir_bad, e.cir); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            begin failures++; $display("FAIL release valid/ready got=%b%b want=01", rsp_valid, cmd_ready); end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({cmd_ready, rsp_valid, tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti} !== 9'b1_0000_0001)
            begin failures++; $display("FAIL %s ctrl got=%b want=100000001", tag,
                {cmd_ready, rsp_valid, tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}); end
        checks++;
        if (rsp_dr !== 38'h0) begin failures++; $display("FAIL %s rsp_dr got=%h want=0", tag, rsp_dr); end
        checks++;
        if ({rsp_ir, ir_in} !== 4'b0) begin failures++; $display("FAIL %s rsp_ir/ir_in got=%b want=0000", tag, {rsp_ir, ir_in}); end
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1;
        @(negedge clk);
        check_reset_outputs("post_reset");
    endtask

    task automatic test_loopback();
        loop = 1; ir_out = 2'b11;
        send(2'b10, 38'h15_5555_5555, 38'h15_5555_5555);
        collect();
    endtask

    task automatic test_strobes();
        int bu = r_uir, bc = r_cdr, bs = r_sdr, bd = r_udr, br = r_rti, bh = sdr_hi, bm = multi_err, bt = tdi_err;
        loop = 1; ir_out = 2'b00;
        send(2'b01, 38'h2A_F0F0_1234, 38'h2A_F0F0_1234);
        collect();
        checks++;
        if ({r_uir - bu, r_cdr - bc, r_udr - bd} !== {32'd1, 32'd1, 32'd1})
            begin failures++; $display("FAIL tck_uir_cdr_udr got=%0d,%0d,%0d want=1,1,1", r_uir - bu, r_cdr - bc, r_udr - bd); end
        checks++;
        if (r_sdr - bs !== 38) begin failures++; $display("FAIL tck_sdr got=%0d want=38", r_sdr - bs); end
        checks++;
        if (r_rti - br !== 2) begin failures++; $display("FAIL tck_rti got=%0d want=2", r_rti - br); end
        checks++;
        if (sdr_hi - bh !== 152) begin failures++; $display("FAIL vs_sdr_clk got=%0d want=152", sdr_hi - bh); end
        checks++;
        if (multi_err != bm) begin failures++; $display("FAIL strobe_overlap got=%0d want=%0d", multi_err, bm); end
        checks++;
        if (tdi_err != bt) begin failures++; $display("FAIL tdi_edge got=%0d want=%0d", tdi_err, bt); end
    endtask

    task automatic test_capture();
        int bt = tdi_err;
        loop = 0; model = 38'h3F_0000_0001; ir_out = 2'b01;
        send(2'b11, 38'h00_1234_5678, 38'h3F_0000_0001);
        collect();
        checks++;
        if (tdi_err != bt) begin failures++; $display("FAIL capture_tdi_edge got=%0d want=%0d", tdi_err, bt); end
        loop = 1;
    endtask

    task automatic test_handshake();
        logic [37:0] snap;
        int n = 0, unstable = 0;
        ir_out = 2'b10;
        send(2'b01, 38'h0A_BCDE_F012, 38'h0A_BCDE_F012);
        while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
        snap = rsp_dr;
        repeat (50) begin
            @(negedge clk);
            if (rsp_dr !== snap || rsp_valid !== 1'b1 || cmd_ready !== 1'b0) unstable++;
        end
        checks++;
        if (unstable != 0) begin failures++; $display("FAIL hold_stable got=%0d want=0", unstable); end
        checks++;
        if (snap !== 38'h0A_BCDE_F012) begin failures++; $display("FAIL hold_rsp_dr got=%h want=0abcdef012", snap); end
        void'(q.pop_front());
        rsp_ready = 1; cmd_valid = 1; cmd_ir = 2'b10; cmd_dr = 38'h11_2233_4455;
        sdr_base = r_sdr;
        @(negedge clk);
        rsp_ready = 0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL consume_to_idle got=%b want=01", {rsp_valid, cmd_ready}); end
        q.push_back('{cir: 2'b10, ir: ir_out, dr: 38'h11_2233_4455});
        @(negedge clk);
        cmd_valid = 0;
        cyc_acc = cyc;
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL back_to_back_accept got=%b want=0", cmd_ready); end
        collect();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ir_out = 2'b11;
        send(2'b10, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF);
        while (r_sdr - sdr_base < 20 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (vs_sdr !== 1'b1) begin failures++; $display("FAIL mid_in_sdr got=%b want=1", vs_sdr); end
        #2 reset_n = 0;
        #1 check_reset_outputs("async_reset");
        void'(q.pop_front());
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (200) @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL no_partial_rsp got=%b want=01", {rsp_valid, cmd_ready}); end
        send(2'b01, 38'h05_A5A5_A5A5, 38'h05_A5A5_A5A5);
        collect();
    endtask

    task automatic test_ignore();
        int n = 0;
        ir_out = 2'b01;
        send(2'b11, 38'h12_3456_789A, 38'h12_3456_789A);
        while (r_sdr - sdr_base < 10 && n < 1000) begin @(negedge clk); n++; end
        cmd_valid = 1; cmd_ir = 2'b00; cmd_dr = 38'h2D_DEAD_BEEF;
        @(negedge clk);
        cmd_valid = 0;
        collect();
        repeat (20) @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready, vs_uir} !== 3'b010) begin failures++; $display("FAIL ignored_cmd got=%b want=010", {rsp_valid, cmd_ready, vs_uir}); end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", q.size()); end
    endtask

    initial begin
        reset_n = 0; cmd_valid = 0; rsp_ready = 0; cmd_ir = 0; cmd_dr = 0;
        ir_out = 0; loop = 1; model = 0;
        test_reset();
        test_loopback();
        test_strobes();
        test_capture();
        test_handshake();
        test_reset_mid();
        test_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
